barrett_sched: RTL and testbench
================================

// Module: barrett_sched
// PURPOSE
//  Round-robin scheduler sharing one Barrett_Reduction datapath among NREQ
//  requesters. Holds the modulus config (q, mu, k) and issues one z per cycle.
//  Tags each issue with its requester id and returns t on a broadcast response bus.
//  The datapath has no valid or stall, so this block tracks in-flight work and
//  drains the pipe before any config change.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  ID_W  2  requester id width, = clog2(NREQ)
//  LAT   3  datapath latency, bru_z/q/mu/k in -> bru_t out, in clk edges
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         asynchronous reset, active low
//  req_valid   in   NREQ      request i has z pending
//  req_z       in   NREQ*128  z of requester i at bits [128*i +: 128]
//  req_ready   out  NREQ      one-hot grant; transfer = valid&ready at clk edge
//  cfg_valid   in   1         new modulus config pending
//  cfg_q       in   64        modulus q
//  cfg_mu      in   31        Barrett constant mu
//  cfg_k       in   8         shift k (0..127)
//  cfg_ready   out  1         1-cycle pulse: cfg consumed (accepted or rejected)
//  cfg_err     out  1         valid with cfg_ready; 1 = rejected (cfg_q == 0)
//  bru_z       out  128       to datapath z (registered)
//  bru_q/mu/k  out  64/31/8   to datapath, driven from config registers
//  bru_t       in   64        from datapath t
//  resp_valid  out  1         result valid (no backpressure; sinks must take it)
//  resp_id     out  ID_W      requester that owns resp_t
//  resp_t      out  64        z mod q (== bru_t)
//  busy        out  1         in-flight count != 0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=UNCFG; all outputs, config regs, bru_z, tag/valid pipe, rr pointer = 0.
//   - In-flight results are discarded. resp_valid falls immediately.
//  FSM:
//   - UNCFG: req_ready=0. On cfg_valid: cfg_ready=1 that cycle.
//     q!=0 -> latch config, go RUN. q==0 -> cfg_err=1, stay UNCFG.
//   - RUN: arbitrate requests. On cfg_valid: issue nothing this cycle, go DRAIN.
//   - DRAIN: req_ready=0. When in-flight == 0: cfg_ready=1.
//     q!=0 -> latch config. q==0 -> cfg_err=1, keep old config.
//     Either way, go RUN.
//  Arbitration (RUN, cfg_valid=0):
//   - req_ready is combinational, at most one bit set.
//   - Grant the first valid index at or after rr_ptr, wrapping NREQ-1 -> 0.
//   - On a grant to i: rr_ptr <= (i+1) mod NREQ. No grant -> rr_ptr unchanged.
//   - Dropping req_valid without a grant is legal.
//  Issue and latency:
//   - Grant of i in cycle c: bru_z <= req_z[i] at end of c.
//   - Tag/valid shift register has LAT+1 stages. Stage 0 <= {1,i} at end of c.
//   - resp_valid=1, resp_id=i, resp_t=bru_t in cycle c+LAT+1 (c+4 by default).
//   - Responses return in issue order. Throughput is 1 per cycle.
//   - bru_z holds its last value when idle. Unit output while no tag is valid is ignored.
//  In-flight counter (0..LAT+1):
//   - +1 on issue, -1 on resp_valid. Simultaneous issue and retire -> unchanged.
//  Config:
//   - bru_q/mu/k change only in UNCFG/DRAIN with in-flight==0.
//   - The datapath's last stage uses q, so q must stay stable until that stage retires.
//   - k>127 is accepted as-is; the result is undefined (caller's responsibility).
//  cfg_valid must stay high until cfg_ready. cfg_* must be stable while cfg_valid=1.
// TESTING
//  1. Reset; cfg q=97, mu=floor(2^k/q), k=14; req0 z=1000
//     -> cfg_ready with cfg_err=0; resp id0 t=30 exactly 4 cycles after grant.
//  2. All 4 req_valid held high for 8 cycles
//     -> grants 0,1,2,3,0,1,2,3; responses in the same order, back-to-back.
//  3. cfg_valid while 3 results are in flight
//     -> req_ready=0 until all 3 retire with the old q; cfg_ready next;
//        then a new req uses the new q.
//  4. cfg q=0 in RUN -> cfg_ready=1, cfg_err=1; old config kept; requests proceed.
//  5. rst_n low with 2 in flight -> resp_valid=0 at once, no stale responses after
//     release, state UNCFG, req_ready=0 until a cfg is accepted.
//  6. Random z (including 0 and 2^128-1), 1000 requests
//     -> every resp_t == z mod q; per-id order preserved; busy low when idle.

Source files
------------

// File: rtl/barrett_sched.sv
// barrett_sched: round-robin scheduler sharing one Barrett reduction datapath among NREQ requesters
module barrett_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ),
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*128-1:0]  req_z,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cfg_valid,
  input  logic [63:0]          cfg_q,
  input  logic [30:0]          cfg_mu,
  input  logic [7:0]           cfg_k,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic [127:0]         bru_z,
  output logic [63:0]          bru_q,
  output logic [30:0]          bru_mu,
  output logic [7:0]           bru_k,
  input  logic [63:0]          bru_t,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [63:0]          resp_t,
  output logic                 busy
);
  localparam int CW = $clog2(LAT + 2);
  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;
  state_t                r_st;
  logic [ID_W-1:0]       r_rr;
  logic [ID_W-1:0]       w_gid;
  logic [ID_W:0]         w_sum;
  logic                  w_hit;
  logic                  w_issue;
  logic [LAT:0]          r_tv;
  logic [LAT:0][ID_W-1:0] r_tid;
  logic [CW-1:0]         r_cnt;
  // scan downwards so the nearest valid index at or after r_rr wins
  always_comb begin
    w_gid = '0;
    w_hit = 1'b0;
    w_sum = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      w_sum = {1'b0, r_rr} + (ID_W+1)'(j);
      w_sum = (w_sum >= (ID_W+1)'(NREQ)) ? w_sum - (ID_W+1)'(NREQ) : w_sum;
      if (req_valid[w_sum[ID_W-1:0]]) begin
        w_gid = w_sum[ID_W-1:0];
        w_hit = 1'b1;
      end
    end
  end
  assign w_issue    = r_st == RUN && !cfg_valid && w_hit;
  assign req_ready  = w_issue ? NREQ'(1) << w_gid : '0;
  assign cfg_ready  = cfg_valid && (r_st == UNCFG || (r_st == DRAIN && r_cnt == '0));
  assign cfg_err    = cfg_ready && cfg_q == '0;
  assign resp_valid = r_tv[LAT];
  assign resp_id    = r_tid[LAT];
  assign resp_t     = resp_valid ? bru_t : '0;
  assign busy       = r_cnt != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= UNCFG;
      r_rr   <= '0;
      r_tv   <= '0;
      r_tid  <= '0;
      r_cnt  <= '0;
      bru_z  <= '0;
      bru_q  <= '0;
      bru_mu <= '0;
      bru_k  <= '0;
    end else begin
      r_st  <= (cfg_ready && (cfg_q != '0 || r_st == DRAIN)) ? RUN :
               (r_st == RUN && cfg_valid) ? DRAIN : r_st;
      r_tv  <= {r_tv[LAT-1:0], w_issue};
      r_tid <= {r_tid[LAT-1:0], w_gid};
      r_cnt <= r_cnt + CW'(w_issue) - CW'(resp_valid);
      if (w_issue) begin
        bru_z <= req_z[{w_gid, 7'd0} +: 128];
        r_rr  <= (w_gid == ID_W'(NREQ - 1)) ? '0 : w_gid + ID_W'(1);
      end
      // config only reaches the datapath once the pipe is empty
      if (cfg_ready && !cfg_err) begin
        bru_q  <= cfg_q;
        bru_mu <= cfg_mu;
        bru_k  <= cfg_k;
      end
    end
  end
endmodule

// File: tb/tb_barrett_sched.sv
// tb_barrett_sched: directed and random checks of barrett_sched against a queue-based model
module tb_barrett_sched;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int LAT  = 3;
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*128-1:0] req_z;
  logic [NREQ-1:0]     req_ready;
  logic                cfg_valid;
  logic [63:0]         cfg_q;
  logic [30:0]         cfg_mu;
  logic [7:0]          cfg_k;
  logic                cfg_ready;
  logic                cfg_err;
  logic [127:0]        bru_z;
  logic [63:0]         bru_q;
  logic [30:0]         bru_mu;
  logic [7:0]          bru_k;
  logic [63:0]         bru_t;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [63:0]         resp_t;
  logic                busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrett_sched #(.NREQ(NREQ), .ID_W(ID_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_k(cfg_k),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .bru_z(bru_z), .bru_q(bru_q), .bru_mu(bru_mu), .bru_k(bru_k), .bru_t(bru_t),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_t(resp_t), .busy(busy)
  );

  // stand-in datapath: LAT edges from bru_z to bru_t, q applied at the last stage
  logic [127:0] d1, d2, d3;
  always @(posedge clk) begin
    d1 <= bru_z;
    d2 <= d1;
    d3 <= d2;
  end
  assign bru_t = (bru_q == 64'd0) ? 64'd0 : 64'(d3 % {64'd0, bru_q});

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [63:0] t;
  } exp_t;
  exp_t        exq[$];
  int          cyc = 0;
  int          mst = 0;
  int          rr = 0;
  int          ngrant = 0;
  logic [63:0] mq = '0;
  logic [30:0] mmu = '0;
  logic [7:0]  mk = '0;
  int          glog[$];
  int          rid[$];
  logic [63:0] rt[$];
  int          rc[$];

  // model: mst 0=unconfigured, 1=running, 2=draining; exq holds issued work by due cycle
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    logic ecr;
    int g;
    if (!rst_n) begin
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bru_z", bru_z, 0);
      chk("rst_bru_q", bru_q, 0);
      exq.delete();
      mst = 0;
      rr = 0;
      mq = '0;
      mmu = '0;
      mk = '0;
    end else begin
      ecr = cfg_valid && (mst == 0 || (mst == 2 && exq.size() == 0));
      chk("busy", busy, exq.size() != 0);
      if (exq.size() > 0 && exq[0].due == cyc) begin
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, exq[0].id);
        chk("resp_t", resp_t, exq[0].t);
        rid.push_back(exq[0].id);
        rt.push_back(exq[0].t);
        rc.push_back(cyc);
        void'(exq.pop_front());
      end else
        chk("resp_valid", resp_valid, 0);
      g = -1;
      if (mst == 1 && !cfg_valid)
        for (int j = 0; j < NREQ && g < 0; j++)
          if (req_valid[(rr + j) % NREQ]) g = (rr + j) % NREQ;
      er = (g < 0) ? '0 : NREQ'(1) << g;
      chk("req_ready", req_ready, er);
      chk("cfg_ready", cfg_ready, ecr);
      chk("cfg_err", cfg_err, ecr && cfg_q == 64'd0);
      chk("bru_q", bru_q, mq);
      chk("bru_mu", bru_mu, mmu);
      chk("bru_k", bru_k, mk);
      if (g >= 0) begin
        exq.push_back('{cyc + LAT + 1, g, 64'(req_z[128*g +: 128] % {64'd0, mq})});
        glog.push_back(g);
        rr = (g + 1) % NREQ;
        ngrant++;
      end
      if (ecr) begin
        if (cfg_q != 64'd0) begin
          mq = cfg_q;
          mmu = cfg_mu;
          mk = cfg_k;
        end
        mst = (mst == 0 && cfg_q == 64'd0) ? 0 : 1;
      end else if (mst == 1 && cfg_valid)
        mst = 2;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] q, input logic [30:0] mu, input logic [7:0] k, output logic err);
    bit got = 0;
    err = 1'b0;
    cfg_valid = 1'b1;
    cfg_q = q;
    cfg_mu = mu;
    cfg_k = k;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1;
        err = cfg_err;
      end
      tick();
    end
    cfg_valid = 1'b0;
    chk("cfg_handshake", got, 1);
  endtask

  task automatic single(input int id, input logic [127:0] z, output int lat, output logic [63:0] t);
    bit g = 0;
    lat = -1;
    t = '0;
    req_z[128*id +: 128] = z;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 40 && !g; i++) begin
      @(negedge clk);
      g = req_ready[id];
      tick();
    end
    req_valid[id] = 1'b0;
    chk("grant_seen", g, 1);
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        t = resp_t;
      end
      tick();
    end
    chk("resp_seen", lat > 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    logic err;
    int lat;
    logic [63:0] t;
    int tv[4];
    int s, n, r;
    req_valid = '0;
    req_z = '0;
    cfg_valid = 1'b0;
    cfg_q = '0;
    cfg_mu = '0;
    cfg_k = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    // basic config and one request: 1000 mod 97 = 30, four cycles after grant
    do_cfg(64'd97, 31'd168, 8'd14, err);
    chk("t1_cfg_err", err, 0);
    single(0, 128'd1000, lat, t);
    chk("t1_latency", lat, 4);
    chk("t1_t", t, 30);
    single(3, 128'd96, lat, t);
    chk("t1_warm_t", t, 96);
    // all requesters busy for eight cycles
    glog.delete(); rid.delete(); rt.delete(); rc.delete();
    req_z = {128'd96, 128'd97, 128'd200, 128'd1000};
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    wait_idle();
    tv = '{30, 6, 0, 96};
    chk("t2_ngrant", glog.size(), 8);
    chk("t2_nresp", rid.size(), 8);
    for (int i = 0; i < 8 && i < glog.size() && i < rid.size(); i++) begin
      chk("t2_grant", glog[i], i % 4);
      chk("t2_resp_id", rid[i], i % 4);
      chk("t2_resp_t", rt[i], tv[i % 4]);
      chk("t2_b2b", rc[i] - rc[0], i);
    end
    // config change with three in flight: old q for them, new q (101) after
    rid.delete(); rt.delete(); rc.delete();
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = 4'b0001;
    do_cfg(64'd101, 31'd162, 8'd14, err);
    chk("t3_cfg_err", err, 0);
    chk("t3_drained", rt.size(), 3);
    for (int i = 0; i < 3 && i < rt.size(); i++) chk("t3_old_t", rt[i], tv[i]);
    single(0, 128'd1000, lat, t);
    chk("t3_new_t", t, 91);
    // rejected config keeps q=101
    do_cfg(64'd0, 31'd5, 8'd9, err);
    chk("t4_err", err, 1);
    chk("t4_q_kept", bru_q, 101);
    single(1, 128'd1000, lat, t);
    chk("t4_t", t, 91);
    // reset with two in flight, one of them presenting its result
    req_z[0 +: 128] = 128'd7;
    req_z[128 +: 128] = 128'd8;
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t5_resp_before_rst", resp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_resp_dropped", resp_valid, 0);
    chk("t5_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale", resp_valid, 0);
      chk("t5_uncfg_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;
    // large prime q = 2^64-59: (2^128-1) mod q = 59^2-1 = 3480
    do_cfg(64'hFFFF_FFFF_FFFF_FFC5, 31'h7FFF_FFFF, 8'd127, err);
    chk("t6_cfg_err", err, 0);
    single(1, '1, lat, t);
    chk("t6_allones", t, 3480);
    single(2, 128'd0, lat, t);
    chk("t6_zero", t, 0);
    s = ngrant;
    n = 0;
    while (ngrant - s < 1000 && n < 20000) begin
      for (int j = 0; j < NREQ; j++) begin
        r = $urandom_range(0, 15);
        req_z[128*j +: 128] = (r == 0) ? 128'd0 : (r == 1) ? '1 : {$urandom, $urandom, $urandom, $urandom};
      end
      req_valid = NREQ'($urandom_range(0, 15));
      tick();
      n++;
    end
    req_valid = '0;
    chk("t6_count", ngrant - s, 1000);
    wait_idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
